// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, bounce filter, edge pulses and press toggle
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset; clears every flop
//   btn_in     raw button pins, asynchronous to clk, bit i = BTN(i+1)
//   btn_level  debounced level per button
//   btn_rise   one-cycle pulse in the first cycle btn_level shows a 0->1 change
//   btn_fall   one-cycle pulse in the first cycle btn_level shows a 1->0 change
//   btn_toggle inverts on every accepted press (same edge as btn_rise)

module btn_debounce #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall,
    output logic [WIDTH-1:0] btn_toggle
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Terminal count: the counter is consumed here and never wraps.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Synchroniser chain; index 0 takes the raw pin, the top index is "sync".
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;

    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         level_q, level_d;
    logic [WIDTH-1:0]         rise_q, rise_d;
    logic [WIDTH-1:0]         fall_q, fall_d;
    logic [WIDTH-1:0]         toggle_q, toggle_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            toggle_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_in};
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
        end
    end

    // Per bit: STABLE when sync matches the accepted level (counter held at 0),
    // PENDING otherwise. Any return to the accepted level restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = '0;
        fall_d   = '0;
        toggle_d = toggle_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                level_d[i]  = sync[i];
                // Pulses are registered alongside the level so they appear in
                // exactly the cycle the new level is first visible.
                rise_d[i]   = sync[i];
                fall_d[i]   = ~sync[i];
                toggle_d[i] = toggle_q[i] ^ sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign btn_level  = level_q;
    assign btn_rise   = rise_q;
    assign btn_fall   = fall_q;
    assign btn_toggle = toggle_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce against a sample-window reference model

module tb_btn_debounce;

    localparam int W = 3;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] btn_in = '0;
    logic [W-1:0] btn_level, btn_rise, btn_fall, btn_toggle;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    btn_debounce #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .btn_toggle(btn_toggle)
    );

    always #5 clk = ~clk;

    // Expected {level, rise, fall, toggle}, one entry per clock edge.
    logic [4*W-1:0] exp_q[$];

    // Reference model: hist holds the pin value sampled at each edge since reset
    // (zeros standing in for the cleared synchroniser). A bit's level flips when
    // the D most recent synchronised samples all disagree with it; the value
    // that reaches the filter at edge e is the pin sampled S edges earlier.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_tog   = '0;
    logic [W-1:0] m_rise, m_fall;
    logic         all_diff;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < S + D; i++) hist.push_back('0);
            m_level = '0;
            m_tog   = '0;
            exp_q.push_back('0);
        end else begin
            hist.push_back(btn_in);
            if (hist.size() > S + D + 1) void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[hist.size() - 1 - S - j][b] == m_level[b]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_level[b]) m_fall[b] = 1'b1;
                    else            m_rise[b] = 1'b1;
                end
            end
            m_level = m_level ^ (m_rise | m_fall);
            m_tog   = m_tog ^ m_rise;
            exp_q.push_back({m_level, m_rise, m_fall, m_tog});
        end
    end

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    logic [4*W-1:0] got, want;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {btn_level, btn_rise, btn_fall, btn_toggle};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d actual lvl/rise/fall/tog=%b_%b_%b_%b required=%b_%b_%b_%b",
                         cyc, got[4*W-1:3*W], got[3*W-1:2*W], got[2*W-1:W], got[W-1:0],
                         want[4*W-1:3*W], want[3*W-1:2*W], want[2*W-1:W], want[W-1:0]);
            end
        end
    end

    task automatic check_zero(input string name);
        logic [4*W-1:0] v;
        v = {btn_level, btn_rise, btn_fall, btn_toggle};
        n_cmp++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL %s actual=%h required=0", name, v);
        end
    endtask

    // Drive a value just after a negedge and hold it for n cycles.
    task automatic hold(input logic [W-1:0] v, input int n);
        btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    int run;

    initial begin
        #1 check_zero("reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Clean press on bit0, then release, then second press.
        hold(3'b001, 10);
        hold(3'b000, 10);
        hold(3'b001, 10);
        hold(3'b000, 10);

        // Bounce on bit1 then held.
        hold(3'b010, 2); hold(3'b000, 2); hold(3'b010, 2); hold(3'b000, 2);
        hold(3'b010, 10);
        hold(3'b000, 10);

        // Short 3-cycle glitch on bit2.
        hold(3'b100, 3);
        hold(3'b000, 10);

        // Simultaneous bits 0 and 2.
        hold(3'b101, 10);
        hold(3'b000, 10);

        // Press bit0 to make toggle nonzero, then reset mid-count of a new press.
        hold(3'b001, 10);
        hold(3'b000, 10);
        hold(3'b011, 2);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        hold(3'b011, 12);
        hold(3'b000, 10);

        // Randomized runs: mixed glitch and accepted lengths, occasional reset.
        for (int k = 0; k < 120; k++) begin
            run = $urandom_range(1, 8);
            if ($urandom_range(0, 29) == 0) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1 check_zero("async_reset_rand");
                @(negedge clk);
                #2 rst = 1'b0;
            end
            hold(W'($urandom), run);
        end
        hold(3'b000, 12);

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
